// File: rtl/calc_result_display.sv
// +----------------------------------------------------------------------------+
// | calc_result_display: 8-bit result -> BCD -> 4-digit seven-segment scanner   |
// | Option macro: LEADING_ZERO_BLANK_EN.  Rev 1.0                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module calc_result_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] result,
  input  logic       err,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LATCH = 2'd2} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  state_t           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [9:0]       bcd_q, bcd_d, bcd_adj;
  logic [7:0]       last_q, last_d;
  logic [2:0]       scnt_q, scnt_d;
  logic             force_q, force_d;
  logic [3:0]       hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             tick;
  logic             blank_hund, blank_tens;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcd_q   <= '0;
      last_q  <= '0;
      scnt_q  <= '0;
      force_q <= 1'b1;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      rcnt_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'b1111;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      last_q  <= last_d;
      scnt_q  <= scnt_d;
      force_q <= force_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  // Hundreds nibble is only 2 bits wide and never reaches 5, so it needs no adjust.
  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    last_d  = last_q;
    scnt_d  = scnt_q;
    force_d = force_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if ((result != last_q) || force_q) begin
          shreg_d = result;
          last_d  = result;
          bcd_d   = '0;
          force_d = 1'b0;
          scnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        scnt_d = scnt_q + 3'd1;
        if (scnt_q == 3'd7) state_d = LATCH;
      end
      LATCH: begin
        hund_d  = {2'b00, bcd_q[9:8]};
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick   = (rcnt_q == CNT_W'(REFRESH_DIV - 1));
  assign rcnt_d = tick ? '0 : rcnt_q + CNT_W'(1);
  assign idx_d  = tick ? idx_q + 2'd1 : idx_q;

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_hund = (hund_q == 4'd0);
  assign blank_tens = blank_hund && (tens_q == 4'd0);
`else
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  // Anode and segment data are both derived from idx_q so they land on the same edge.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = err ? SEG_DASH : seg7(ones_q);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = err ? SEG_DASH : (blank_tens ? SEG_BLANK : seg7(tens_q));
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = err ? SEG_DASH : (blank_hund ? SEG_BLANK : seg7(hund_q));
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = err ? SEG_E : SEG_BLANK;
      end
    endcase
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;
  assign busy = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_calc_result_display.sv
// +----------------------------------------------------------------------------+
// | tb_calc_result_display: directed scoreboard bench for calc_result_display   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_calc_result_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] result = 8'd0;
  logic       err = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int v;

  calc_result_display #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .result (result),
    .err    (err),
    .seg    (seg),
    .an     (an),
    .dp     (dp),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] dig7(input int d);
    case (d)
      0: dig7 = 7'b1000000;
      1: dig7 = 7'b1111001;
      2: dig7 = 7'b0100100;
      3: dig7 = 7'b0110000;
      4: dig7 = 7'b0011001;
      5: dig7 = 7'b0010010;
      6: dig7 = 7'b0000010;
      7: dig7 = 7'b1111000;
      8: dig7 = 7'b0000000;
      9: dig7 = 7'b0010000;
      default: dig7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int val, input logic [3:0] a, input logic e);
    int h, t, o;
    bit bh, bt;
    h  = val / 100;
    t  = (val / 10) % 10;
    o  = val % 10;
    bh = 1'b0;
    bt = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    bh = (h == 0);
    bt = (h == 0) && (t == 0);
`endif
    case (a)
      4'b1110: exp_seg = e ? 7'b0111111 : dig7(o);
      4'b1101: exp_seg = e ? 7'b0111111 : (bt ? 7'b1111111 : dig7(t));
      4'b1011: exp_seg = e ? 7'b0111111 : (bh ? 7'b1111111 : dig7(h));
      4'b0111: exp_seg = e ? 7'b0000110 : 7'b1111111;
      default: exp_seg = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int bound);
    int n;
    n = 0;
    while (busy !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(lvl ? "wait_busy_high" : "wait_busy_low", 32'(busy), 32'(lvl));
  endtask

  task automatic window(input int val, input logic e, input int n);
    logic [3:0] prev;
    int run;
    bit seen;
    prev = 4'b1111;
    run  = 0;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("seg", 32'(seg), 32'(exp_seg(val, an, e)));
      chk("an_onecold", 32'($countones(~an)), 32'd1);
      if (i > 0 && an != prev) begin
        chk("an_next", 32'(an), 32'({prev[2:0], prev[3]}));
        if (seen) chk("an_period", 32'(run), 32'd4);
        seen = 1'b1;
        run  = 1;
      end else begin
        run++;
      end
      prev = an;
    end
    chk("dp", 32'(dp), 32'd1);
  endtask

  task automatic pop_expected(output int val);
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed 0 entries expected >0");
      val = -1;
    end else begin
      val = sb.pop_front();
    end
  endtask

  task automatic finish_conv(input int n, input int bound);
    int pv;
    wait_busy(1'b1, 20);
    wait_busy(1'b0, bound);
    pop_expected(pv);
    @(posedge clk);
    window(pv, 1'b0, n);
  endtask

  initial begin
    // Reset state and forced conversion of result=0
    sb.push_back(0);
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h7f);
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dp", 32'(dp), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      chk("busy_after_reset", 32'(busy), (k <= 9) ? 32'd1 : 32'd0);
    end
    pop_expected(v);
    @(posedge clk);
    window(v, 1'b0, 16);

    @(negedge clk);
    result = 8'd255;
    sb.push_back(255);
    finish_conv(16, 20);

    // Change lands mid-conversion; old value must display first
    @(negedge clk);
    result = 8'd100;
    sb.push_back(100);
    wait_busy(1'b1, 20);
    repeat (3) @(negedge clk);
    result = 8'd37;
    sb.push_back(37);
    finish_conv(8, 20);
    finish_conv(16, 20);

    @(negedge clk);
    result = 8'd42;
    sb.push_back(42);
    finish_conv(16, 20);
    @(negedge clk);
    err = 1'b1;
    @(posedge clk);
    window(42, 1'b1, 16);
    @(negedge clk);
    err = 1'b0;
    @(posedge clk);
    window(42, 1'b0, 16);

    // Asynchronous reset in the middle of SHIFT
    @(negedge clk);
    result = 8'd200;
    sb.push_back(200);
    wait_busy(1'b1, 20);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h7f);
    chk("async_rst_an", 32'(an), 32'hf);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    finish_conv(16, 12);

    @(negedge clk);
    result = 8'd7;
    sb.push_back(7);
    finish_conv(16, 20);
    @(negedge clk);
    result = 8'd0;
    sb.push_back(0);
    finish_conv(16, 20);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
